// File: rtl/neander_bus_bridge.sv
// Bridge between the NEANDER-X core strobes, a memory-mapped I/O window and an
// external RAM request/acknowledge port with timeout and core stall.
module neander_bus_bridge #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int N_IO    = 2,
  parameter int IO_BASE = 'hF0,
  parameter int TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [ADDR_W-1:0]      cpu_addr,
  input  logic [DATA_W-1:0]      cpu_wdata,
  input  logic                   cpu_read,
  input  logic                   cpu_write,
  output logic [DATA_W-1:0]      cpu_rdata,
  output logic                   cpu_ce,
  output logic                   ram_req,
  output logic                   ram_we,
  output logic [ADDR_W-1:0]      ram_addr,
  output logic [DATA_W-1:0]      ram_wdata,
  input  logic [DATA_W-1:0]      ram_rdata,
  input  logic                   ram_ack,
  input  logic [N_IO*DATA_W-1:0] io_in,
  input  logic [N_IO*DATA_W-1:0] io_status,
  output logic [N_IO*DATA_W-1:0] io_out,
  output logic [N_IO-1:0]        io_wr,
  output logic                   bus_err,
  input  logic                   err_clr,
  output logic [1:0]             fsm_state
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W:0] IO_LO = (ADDR_W+1)'(IO_BASE);
  localparam logic [ADDR_W:0] IO_HI = (ADDR_W+1)'(IO_BASE + 2 * N_IO);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2} state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt;
  logic [DATA_W-1:0]  data_q;
  logic [DATA_W-1:0]  io_sel;
  logic [ADDR_W-1:0]  offset;
  logic [ADDR_W-1:0]  ch_full;
  logic               io_hit;
  logic               access;
  logic               rd_only;
  logic               ram_start;
  logic               io_write;
  logic               cnt_at_limit;
  logic               timeout_hit;

  assign fsm_state = state;

  // Window decode is done one bit wider so the top of the window cannot wrap.
  assign io_hit  = ({1'b0, cpu_addr} >= IO_LO) && ({1'b0, cpu_addr} < IO_HI);
  assign offset  = cpu_addr - ADDR_W'(IO_BASE);
  assign ch_full = offset >> 1;
  assign access  = cpu_read | cpu_write;
  assign rd_only = cpu_read & ~cpu_write;

  assign io_write     = (state == IDLE) && cpu_write && io_hit && !offset[0];
  assign cnt_at_limit = (cnt == CNT_W'(TIMEOUT));
  assign timeout_hit  = (state == WAIT) && !ram_ack && cnt_at_limit;

  always_comb begin
    io_sel = '0;
    for (int i = 0; i < N_IO; i++) begin
      if (ch_full == ADDR_W'(i)) begin
        io_sel = offset[0] ? io_status[i*DATA_W +: DATA_W] : io_in[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_n   = state;
    cpu_ce    = 1'b1;
    cpu_rdata = '0;
    ram_start = 1'b0;
    case (state)
      IDLE: begin
        if (access) begin
          if (io_hit) begin
            if (rd_only) cpu_rdata = io_sel;
          end else begin
            cpu_ce    = 1'b0;
            ram_start = 1'b1;
            state_n   = WAIT;
          end
        end
      end
      WAIT: begin
        cpu_ce = 1'b0;
        if (ram_ack || cnt_at_limit) state_n = DONE;
      end
      DONE: begin
        // Strobes seen here belong to the access that is completing.
        cpu_rdata = data_q;
        state_n   = IDLE;
      end
      default: state_n = IDLE;
    endcase
    // The core must never be frozen while the bridge itself is held in reset.
    if (!reset) cpu_ce = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ram_req   <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      io_out    <= '0;
      io_wr     <= '0;
      cnt       <= '0;
      data_q    <= '0;
    end else begin
      io_wr <= '0;
      if (io_write) begin
        for (int i = 0; i < N_IO; i++) begin
          if (ch_full == ADDR_W'(i)) begin
            io_out[i*DATA_W +: DATA_W] <= cpu_wdata;
            io_wr[i]                   <= 1'b1;
          end
        end
      end
      if (ram_start) begin
        ram_req   <= 1'b1;
        ram_we    <= cpu_write;
        ram_addr  <= cpu_addr;
        ram_wdata <= cpu_wdata;
        cnt       <= CNT_W'(1);
      end
      if (state == WAIT) begin
        if (ram_ack) begin
          ram_req <= 1'b0;
          if (!ram_we) data_q <= ram_rdata;
        end else if (cnt_at_limit) begin
          ram_req <= 1'b0;
          data_q  <= '1;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

  // A timeout in the same cycle as err_clr still leaves the flag set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)           bus_err <= 1'b0;
    else if (timeout_hit) bus_err <= 1'b1;
    else if (err_clr)     bus_err <= 1'b0;
  end

endmodule

// File: tb/tb_neander_bus_bridge.sv
// Bench for neander_bus_bridge: fixed vector table, hand-written reset/ack
// sequences and a randomized run against a transaction-level model.
module tb_neander_bus_bridge;

  localparam int TIMEOUT = 15;
  localparam int IO_BASE = 'hF0;
  localparam int N_IO    = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  cpu_addr = '0;
  logic [7:0]  cpu_wdata = '0;
  logic        cpu_read = 1'b0;
  logic        cpu_write = 1'b0;
  logic [7:0]  cpu_rdata;
  logic        cpu_ce;
  logic        ram_req;
  logic        ram_we;
  logic [7:0]  ram_addr;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata = '0;
  logic        ram_ack = 1'b0;
  logic [15:0] io_in = '0;
  logic [15:0] io_status = '0;
  logic [15:0] io_out;
  logic [1:0]  io_wr;
  logic        bus_err;
  logic        err_clr = 1'b0;
  logic [1:0]  fsm_state;

  int total = 0;
  int bad   = 0;

  neander_bus_bridge #(
    .ADDR_W(8), .DATA_W(8), .N_IO(N_IO), .IO_BASE(IO_BASE), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_rdata(cpu_rdata), .cpu_ce(cpu_ce),
    .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .ram_ack(ram_ack),
    .io_in(io_in), .io_status(io_status), .io_out(io_out), .io_wr(io_wr),
    .bus_err(bus_err), .err_clr(err_clr), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Holds the strobes until the core would see cpu_ce high, pulsing ram_ack in
  // cycle ack_at (0 = never). Returns the number of stalled cycles and the
  // read data seen in the completing cycle.
  task automatic run_access(input logic rd, input logic wr, input logic [7:0] addr,
                            input logic [7:0] wd, input int ack_at, input logic [7:0] rdat,
                            output int stalls, output logic [7:0] data);
    int req_bad = 0;
    int rdata_bad = 0;
    logic done = 1'b0;
    logic [7:0] cap_addr = '0;
    logic [7:0] cap_wdata = '0;
    logic cap_we = 1'b0;
    stalls = 0;
    data = '0;
    cpu_read = rd; cpu_write = wr; cpu_addr = addr; cpu_wdata = wd; ram_rdata = rdat;
    for (int c = 0; c < 40 && !done; c++) begin
      ram_ack = (c >= 1) && (c == ack_at);
      @(negedge clk);
      if (cpu_ce) begin
        data = cpu_rdata;
        done = 1'b1;
        if (ram_req !== 1'b0) req_bad++;
      end else begin
        stalls++;
        if (ram_req !== (c >= 1)) req_bad++;
        if (cpu_rdata !== 8'h00) rdata_bad++;
        if (c == 1) begin
          cap_addr = ram_addr; cap_wdata = ram_wdata; cap_we = ram_we;
        end
      end
      @(posedge clk); #1;
    end
    ram_ack = 1'b0; cpu_read = 1'b0; cpu_write = 1'b0;
    check("access_done", done, 1);
    check("ram_req_window", req_bad, 0);
    check("rdata_zero_in_stall", rdata_bad, 0);
    if (stalls > 1) begin
      check("ram_addr", cap_addr, addr);
      check("ram_we", cap_we, wr);
      if (wr) check("ram_wdata", cap_wdata, wd);
    end
  endtask

  // Idle cycle after an access: io_wr pulse, io_out and bus_err are visible here.
  task automatic gap(input logic clr, input logic [1:0] exp_wr, input logic [15:0] exp_io,
                     input logic exp_err);
    err_clr = clr;
    @(negedge clk);
    check("io_wr", io_wr, exp_wr);
    check("io_out", io_out, exp_io);
    check("bus_err", bus_err, exp_err);
    @(posedge clk); #1;
    err_clr = 1'b0;
  endtask

  typedef struct {
    logic       rd;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    int         ack_at;
    logic [7:0] ram_data;
    logic       clr;
    int         exp_stalls;
    logic [7:0] exp_data;
    logic [1:0] exp_wr;
    logic [15:0] exp_io;
    logic       exp_err;
  } vec_t;

  vec_t vecs[$];

  // Transaction-level reference state.
  logic [7:0] m_io[N_IO];
  logic [7:0] m_latched;
  logic       m_err;

  function automatic logic [15:0] m_io_packed();
    return {m_io[1], m_io[0]};
  endfunction

  initial begin
    int stalls;
    logic [7:0] data;

    // rd wr addr wdata ack data clr | stalls data wr io err
    vecs.push_back('{1, 0, 8'h10, 8'h00,  3, 8'h5A, 0,  4, 8'h5A, 2'b00, 16'h0000, 0});
    vecs.push_back('{1, 0, 8'h20, 8'h00,  1, 8'hC3, 0,  2, 8'hC3, 2'b00, 16'h0000, 0});
    vecs.push_back('{0, 1, 8'hF2, 8'h77,  0, 8'h00, 0,  0, 8'h00, 2'b10, 16'h7700, 0});
    vecs.push_back('{0, 1, 8'hF3, 8'h55,  0, 8'h00, 0,  0, 8'h00, 2'b00, 16'h7700, 0});
    vecs.push_back('{1, 0, 8'hF1, 8'h00,  0, 8'h00, 0,  0, 8'h81, 2'b00, 16'h7700, 0});
    vecs.push_back('{1, 0, 8'hF0, 8'h00,  0, 8'h00, 0,  0, 8'hA1, 2'b00, 16'h7700, 0});
    vecs.push_back('{1, 0, 8'hF3, 8'h00,  0, 8'h00, 0,  0, 8'h42, 2'b00, 16'h7700, 0});
    vecs.push_back('{1, 0, 8'hF2, 8'h00,  0, 8'h00, 0,  0, 8'hB2, 2'b00, 16'h7700, 0});
    vecs.push_back('{1, 0, 8'hF4, 8'h00,  2, 8'h11, 0,  3, 8'h11, 2'b00, 16'h7700, 0});
    vecs.push_back('{1, 0, 8'h30, 8'h00,  0, 8'h00, 0, 16, 8'hFF, 2'b00, 16'h7700, 1});
    vecs.push_back('{1, 1, 8'h40, 8'h33,  2, 8'hEE, 1,  3, 8'hFF, 2'b00, 16'h7700, 1});
    vecs.push_back('{1, 0, 8'h50, 8'h00, 15, 8'h9C, 0, 16, 8'h9C, 2'b00, 16'h7700, 0});
    vecs.push_back('{1, 0, 8'h60, 8'h00, 16, 8'h01, 1, 16, 8'hFF, 2'b00, 16'h7700, 1});
    vecs.push_back('{0, 1, 8'hF0, 8'h12,  0, 8'h00, 0,  0, 8'h00, 2'b01, 16'h7712, 0});

    // Reset and idle.
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("rst_cpu_ce", cpu_ce, 1);
    check("rst_ram_req", ram_req, 0);
    check("rst_ram_we", ram_we, 0);
    check("rst_io_out", io_out, 0);
    check("rst_io_wr", io_wr, 0);
    check("rst_bus_err", bus_err, 0);
    check("rst_cpu_rdata", cpu_rdata, 0);
    @(posedge clk); #1;

    // Fixed vectors.
    io_in = {8'hB2, 8'hA1};
    io_status = {8'h42, 8'h81};
    foreach (vecs[i]) begin
      run_access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].ack_at,
                 vecs[i].ram_data, stalls, data);
      check($sformatf("vec%0d_stalls", i), stalls, vecs[i].exp_stalls);
      check($sformatf("vec%0d_data", i), data, vecs[i].exp_data);
      gap(vecs[i].clr, vecs[i].exp_wr, vecs[i].exp_io, vecs[i].exp_err);
    end

    // Stray ack while idle.
    ram_ack = 1'b1;
    @(negedge clk);
    check("stray_ce", cpu_ce, 1);
    check("stray_req", ram_req, 0);
    @(posedge clk); #1;
    ram_ack = 1'b0;
    @(negedge clk);
    check("stray_req_after", ram_req, 0);
    check("stray_rdata", cpu_rdata, 0);
    @(posedge clk); #1;
    run_access(1, 0, 8'h21, 8'h00, 1, 8'h3C, stalls, data);
    check("post_stray_stalls", stalls, 2);
    check("post_stray_data", data, 8'h3C);
    gap(0, 2'b00, 16'h7712, 0);

    // Reset in the middle of a RAM wait.
    cpu_read = 1'b1; cpu_addr = 8'h70;
    repeat (3) begin @(posedge clk); #1; end
    check("mid_wait_req", ram_req, 1);
    #2 reset = 1'b0;
    #1;
    check("rst_wait_req", ram_req, 0);
    check("rst_wait_ce", cpu_ce, 1);
    cpu_read = 1'b0;
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1 ram_ack = 1'b1; ram_rdata = 8'hD7;
    @(posedge clk); #1 ram_ack = 1'b0;
    @(negedge clk);
    check("late_ack_req", ram_req, 0);
    check("late_ack_ce", cpu_ce, 1);
    check("late_ack_rdata", cpu_rdata, 0);
    check("late_ack_io", io_out, 0);
    @(posedge clk); #1;

    // Randomized accesses against the model, starting from reset state.
    foreach (m_io[i]) m_io[i] = '0;
    m_latched = '0;
    m_err = 1'b0;
    for (int n = 0; n < 150; n++) begin
      int op, ack_at, ch, off, exp_stalls;
      logic rd, wr, hit, clr;
      logic [7:0] addr, wd, rdat, exp_data;
      logic [1:0] exp_wr;
      op = $urandom_range(0, 2);
      rd = (op != 1);
      wr = (op != 0);
      wd = 8'($urandom);
      rdat = 8'($urandom);
      ack_at = $urandom_range(0, TIMEOUT + 2);
      io_in = 16'($urandom);
      io_status = 16'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        addr = 8'(IO_BASE + $urandom_range(0, 2 * N_IO - 1));
      end else begin
        do addr = 8'($urandom_range(0, 255));
        while (addr >= 8'(IO_BASE) && addr < 8'(IO_BASE + 2 * N_IO));
      end
      clr = ($urandom_range(0, 3) == 0);

      hit = (int'(addr) >= IO_BASE) && (int'(addr) < IO_BASE + 2 * N_IO);
      exp_wr = 2'b00;
      if (hit) begin
        off = int'(addr) - IO_BASE;
        ch = off / 2;
        exp_stalls = 0;
        exp_data = 8'h00;
        if (wr) begin
          if (off % 2 == 0) begin
            m_io[ch] = wd;
            exp_wr[ch] = 1'b1;
          end
        end else begin
          exp_data = (off % 2 == 1) ? io_status[ch*8 +: 8] : io_in[ch*8 +: 8];
        end
      end else if (ack_at >= 1 && ack_at <= TIMEOUT) begin
        exp_stalls = ack_at + 1;
        if (!wr) m_latched = rdat;
        exp_data = m_latched;
      end else begin
        exp_stalls = TIMEOUT + 1;
        m_latched = 8'hFF;
        m_err = 1'b1;
        exp_data = m_latched;
      end

      run_access(rd, wr, addr, wd, ack_at, rdat, stalls, data);
      check("rand_stalls", stalls, exp_stalls);
      check("rand_data", data, exp_data);
      gap(clr, exp_wr, m_io_packed(), m_err);
      if (clr) m_err = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
